// File: rtl/bnn_result_sink.sv
// ---------------------------------------------------------------------------
// bnn_result_sink
//
// Launches one BNN inference, collects the NUM_CLASSES signed FC scores the
// core streams back (no backpressure), tracks the running argmax and presents
// the winning class index and score on a valid/ready output.
//
// Parameters
//   NUM_CLASSES     scores per inference (2..16)
//   TIMEOUT_CYCLES  watchdog limit from launch to the final score
//
// Ports
//   clk, rstn        single rising-edge clock, synchronous active-low reset
//   start            request an inference (only honoured in IDLE)
//   start_cnn        one-cycle launch pulse to the core
//   cnn_done         core completion pulse
//   result_tvalid/   score strobe and signed 32-bit score
//   result_tdata
//   class_tvalid/    classification handshake
//   class_tready
//   class_tdata      argmax index
//   max_score        winning signed score
//   busy             high whenever the FSM is not IDLE
//   err              sticky {timeout, overrun, short}, cleared on start
//
// Build option
//   BNN_SINK_TIMEOUT_EN  builds a 16-bit watchdog timer. When undefined no
//                        timer exists, err[2] stays 0 and the FSM waits
//                        indefinitely for the core.
// ---------------------------------------------------------------------------
module bnn_result_sink #(
    parameter int NUM_CLASSES    = 10,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        start_cnn,
    input  logic        cnn_done,
    input  logic        result_tvalid,
    input  logic [31:0] result_tdata,
    output logic        class_tvalid,
    input  logic        class_tready,
    output logic [3:0]  class_tdata,
    output logic [31:0] max_score,
    output logic        busy,
    output logic [2:0]  err
);

    localparam int                 IDX_W     = $clog2(NUM_CLASSES + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [31:0] SCORE_MIN = 32'sh8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_COLLECT,
        S_WAIT_DONE,
        S_OUTPUT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;          // scores accepted so far
    logic signed [31:0] best_q, best_d;        // running maximum
    logic [3:0]         best_idx_q, best_idx_d;
    logic [2:0]         err_q, err_d;
    logic               timeout_hit;
    logic               last_score;            // this cycle carries score NUM_CLASSES-1

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
`ifdef BNN_SINK_TIMEOUT_EN
    logic [15:0] timer_q;
    logic        timing;

    assign timing = (state_q == S_COLLECT) || (state_q == S_WAIT_DONE);

    // Fires in the cycle whose edge would bring the timer to TIMEOUT_CYCLES,
    // so OUTPUT is entered TIMEOUT_CYCLES+1 cycles after the launch cycle.
    assign timeout_hit = timing &&
                         (({1'b0, timer_q} + 17'd1) >= 17'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            timer_q <= '0;
        end else if (state_q == S_LAUNCH) begin
            timer_q <= '0;
        end else if (timing && !timeout_hit) begin
            timer_q <= timer_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            err_q      <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    assign last_score = result_tvalid && (idx_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LAUNCH;
                    idx_d      = '0;
                    best_d     = SCORE_MIN;
                    best_idx_d = '0;
                    err_d      = '0;
                end
            end

            S_LAUNCH: begin
                state_d = S_COLLECT;
            end

            S_COLLECT: begin
                if (result_tvalid) begin
                    idx_d = idx_q + IDX_W'(1);
                    // Strict compare keeps the lower index on ties; the first
                    // score is forced in so an all-minimum stream reports 0.
                    if ((idx_q == '0) || ($signed(result_tdata) > best_q)) begin
                        best_d     = $signed(result_tdata);
                        best_idx_d = 4'(idx_q);
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = cnn_done ? S_OUTPUT : S_WAIT_DONE;
                    end
                end
                // Completion before the full set (counting this cycle's score)
                // is a short inference: report whatever argmax we have.
                if (cnn_done && !last_score) begin
                    err_d[0] = 1'b1;
                    state_d  = S_OUTPUT;
                end
            end

            S_WAIT_DONE: begin
                if (cnn_done) begin
                    state_d = S_OUTPUT;
                end
            end

            S_OUTPUT: begin
                // start during the handshake is deliberately not looked at.
                if (class_tready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A score outside COLLECT is unexpected; flag it and drop it. This
        // is applied after the IDLE clear so a stray score coincident with
        // start is still reported for the new inference.
        if (result_tvalid && (state_q != S_COLLECT)) begin
            err_d[1] = 1'b1;
        end

        if (timeout_hit) begin
            err_d[2] = 1'b1;
            state_d  = S_OUTPUT;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign start_cnn    = (state_q == S_LAUNCH);
    assign class_tvalid = (state_q == S_OUTPUT);
    assign busy         = (state_q != S_IDLE);
    assign class_tdata  = best_idx_q;          // held until the next start
    assign max_score    = best_q;
    assign err          = err_q;

endmodule
